// File: rtl/hafsa_sopc_memoire_arbiter.sv
// hafsa_sopc_memoire_arbiter
// Two-master round-robin arbiter in front of the single-port on-chip RAM.
// Supports a per-master grant lock for multi-beat sequences and a 1-cycle
// read return routed to the issuing master. Out-of-range accesses are
// accepted, dropped at the RAM, and counted in a saturating counter.
module hafsa_sopc_memoire_arbiter #(
    parameter int DEPTH = 5120,
    parameter int AW    = 13,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              halt,

    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,

    output logic [AW-1:0]     mem_address,
    output logic [DW/8-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata,

    output logic [CNT_W-1:0]  oor_count
);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic           req0;
    logic           req1;
    logic           grant0;
    logic           grant1;
    logic           granted;
    owner_t         sel_owner;
    logic [AW-1:0]  sel_address;
    logic           sel_write;
    logic           sel_lock;
    logic           in_range;

    owner_t         last_grant;
    logic           lock_valid;
    owner_t         lock_owner;

    logic           rd_pend;
    owner_t         rd_owner;
    logic           rd_oor;
    logic [DW-1:0]  rd_data;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant selection: lock owner first, then round-robin on a tie, else the lone requester
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!halt) begin
            if (lock_valid && (lock_owner == OWN_M0) && req0) begin
                grant0 = 1'b1;
            end else if (lock_valid && (lock_owner == OWN_M1) && req1) begin
                grant1 = 1'b1;
            end else if (req0 && req1) begin
                if (last_grant == OWN_M0) grant1 = 1'b1;
                else                      grant0 = 1'b1;
            end else if (req0) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
    end

    assign granted   = grant0 | grant1;
    assign sel_owner = grant1 ? OWN_M1 : OWN_M0;

    // Request mux toward the RAM port; write wins when read and write are both high
    always_comb begin
        sel_address    = m0_address;
        sel_write      = m0_write;
        sel_lock       = m0_lock;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        if (grant1) begin
            sel_address    = m1_address;
            sel_write      = m1_write;
            sel_lock       = m1_lock;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
    end

    assign in_range       = ({1'b0, sel_address} < DEPTH_LIM);
    assign mem_address    = sel_address;
    assign mem_chipselect = granted & in_range;
    assign mem_write      = granted & sel_write & in_range;
    assign mem_clken      = ~halt;

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    assign rd_data          = rd_oor ? '0 : mem_readdata;
    assign m0_readdata      = rd_data;
    assign m1_readdata      = rd_data;
    assign m0_readdatavalid = rd_pend & (rd_owner == OWN_M0);
    assign m1_readdatavalid = rd_pend & (rd_owner == OWN_M1);

    // Round-robin history and grant lock; both frozen while halted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWN_M1;
            lock_valid <= 1'b0;
            lock_owner <= OWN_M0;
        end else if (granted) begin
            last_grant <= sel_owner;
            lock_valid <= sel_lock;
            lock_owner <= sel_owner;
        end else if (!halt) begin
            lock_valid <= 1'b0;
        end
    end

    // One-cycle read return tracking: who issued it and whether it was out of range
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_M0;
            rd_oor   <= 1'b0;
        end else begin
            rd_pend  <= granted & ~sel_write;
            rd_owner <= sel_owner;
            rd_oor   <= ~in_range;
        end
    end

    // Saturating count of accepted out-of-range accesses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_count <= '0;
        end else if (granted && !in_range && (oor_count != '1)) begin
            oor_count <= oor_count + 1'b1;
        end
    end

endmodule
